// File: rtl/acc_requester_pkg.sv
// rtl/acc_requester_pkg.sv - shared constants and request bundle for the accumulator request interface
package acc_requester_pkg;

    localparam int ACC_NUM        = 3;
    localparam int ACC_DEPTH      = 4;
    localparam int ACC_DATA_WIDTH = 32;

    typedef logic [$clog2(ACC_NUM)-1:0] acc_idx_t;

    // One accumulator's request channel as seen by both the core and the parent register file
    typedef struct packed {
        logic                      valid;
        logic                      ready;
        logic [ACC_DATA_WIDTH-1:0] data;
    } acc_req_t;

endpackage

// File: rtl/acc_fifo.sv
// rtl/acc_fifo.sv - single accumulator operand queue with push/ready and valid/ready/data sides
module acc_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_valid,
    input  logic [DATA_WIDTH-1:0]      push_data,
    output logic                       push_ready,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [DATA_WIDTH-1:0]      req_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    // Both handshakes derive from the registered count only, so ready never depends on req_ready
    assign push_ready = (r_count != FULL);
    assign req_valid  = (r_count != '0);
    assign req_data   = r_mem[r_rptr];
    assign count      = r_count;
    assign w_push     = push_valid && push_ready;
    assign w_pop      = req_valid && req_ready;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Operand storage; contents are meaningless while the entry is not counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

endmodule

// File: rtl/acc_requester.sv
// rtl/acc_requester.sv - per-core accumulate request queues toward the shared FADD accumulators
module acc_requester
    import acc_requester_pkg::*;
#(
    parameter int N_ACC      = ACC_NUM,
    parameter int DEPTH      = ACC_DEPTH,
    parameter int DATA_WIDTH = ACC_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              push,
    input  logic [$clog2(N_ACC)-1:0]          push_acc,
    input  logic [DATA_WIDTH-1:0]             push_data,
    output logic [N_ACC-1:0]                  push_ready,
    output logic [N_ACC-1:0]                  req_valid,
    output logic [N_ACC-1:0][DATA_WIDTH-1:0]  req_data,
    input  logic [N_ACC-1:0]                  req_ready,
    output logic                              all_empty,
    output logic                              any_full
);

    localparam int IW = $clog2(N_ACC);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [N_ACC-1:0]  w_push;
    logic [CW-1:0]     w_count [N_ACC];
    logic              w_all_empty;
    logic              w_any_full;

    for (genvar k = 0; k < N_ACC; k++) begin : g_acc
        // Indices at or above N_ACC match no queue and are silently ignored
        assign w_push[k] = push && (push_acc == IW'(k));

        acc_fifo #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk        (clk),
            .reset_n    (reset_n),
            .push_valid (w_push[k]),
            .push_data  (push_data),
            .push_ready (push_ready[k]),
            .req_valid  (req_valid[k]),
            .req_ready  (req_ready[k]),
            .req_data   (req_data[k]),
            .count      (w_count[k])
        );
    end

    // Queue status reduction used by the core for issue stalls and barrier drain
    always_comb begin
        w_all_empty = 1'b1;
        w_any_full  = 1'b0;
        for (int k = 0; k < N_ACC; k++) begin
            if (w_count[k] != '0) begin
                w_all_empty = 1'b0;
            end
            if (w_count[k] == FULL) begin
                w_any_full = 1'b1;
            end
        end
    end

    assign all_empty = w_all_empty;
    assign any_full  = w_any_full;

endmodule

// File: tb/tb_acc_requester.sv
// tb/tb_acc_requester.sv - scoreboard bench for acc_requester
module tb_acc_requester;
    import acc_requester_pkg::*;

    localparam int NA = 3;
    localparam int D  = 4;
    localparam int DW = 32;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    push;
    acc_idx_t                push_acc;
    logic [DW-1:0]           push_data;
    logic [NA-1:0]           push_ready;
    logic [NA-1:0]           req_valid;
    logic [NA-1:0][DW-1:0]   req_data;
    logic [NA-1:0]           req_ready;
    logic                    all_empty;
    logic                    any_full;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q [NA][$];
    int  sz;
    bit  acc_ok;
    bit  exp_empty;
    bit  exp_full;

    always #5 clk = ~clk;

    acc_requester #(.N_ACC(NA), .DEPTH(D), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_acc   (push_acc),
        .push_data  (push_data),
        .push_ready (push_ready),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .all_empty  (all_empty),
        .any_full   (any_full)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the queue model, then advances the model
    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_req_valid", req_valid, '0);
            check("rst_push_ready", push_ready, 3'b111);
            check("rst_all_empty", all_empty, 1'b1);
            check("rst_any_full", any_full, 1'b0);
            for (int k = 0; k < NA; k++) exp_q[k].delete();
        end else begin
            exp_empty = 1'b1;
            exp_full  = 1'b0;
            for (int k = 0; k < NA; k++) begin
                sz = exp_q[k].size();
                if (sz != 0) exp_empty = 1'b0;
                if (sz == D) exp_full = 1'b1;
                check($sformatf("req_valid[%0d]", k), req_valid[k], sz != 0);
                check($sformatf("push_ready[%0d]", k), push_ready[k], sz < D);
                if (sz != 0) begin
                    check($sformatf("req_data[%0d]", k), req_data[k], exp_q[k][0]);
                end
                acc_ok = push && (push_acc == acc_idx_t'(k)) && (sz < D);
                if (sz != 0 && req_ready[k]) void'(exp_q[k].pop_front());
                if (acc_ok) exp_q[k].push_back(push_data);
            end
            check("all_empty", all_empty, exp_empty);
            check("any_full", any_full, exp_full);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input int a, input logic [DW-1:0] d);
        push      = 1'b1;
        push_acc  = acc_idx_t'(a);
        push_data = d;
        cyc();
        push      = 1'b0;
    endtask

    task automatic drain();
        req_ready = '1;
        for (int i = 0; i < 40 && !all_empty; i++) cyc();
        check("drain_all_empty", all_empty, 1'b1);
        req_ready = '0;
        cyc();
    endtask

    initial begin
        reset_n   = 1'b0;
        push      = 1'b0;
        push_acc  = '0;
        push_data = '0;
        req_ready = '0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        cyc();

        // Single push with ready already high: visible next cycle, empty one cycle after
        req_ready[1] = 1'b1;
        do_push(1, 32'h3F80_0000);
        check("t1_valid", req_valid[1], 1'b1);
        check("t1_data", req_data[1], 32'h3F80_0000);
        cyc();
        check("t1_all_empty", all_empty, 1'b1);
        req_ready = '0;
        cyc();

        // Fill acc 0, verify full flags, drop a fifth push, then drain in order
        for (int i = 1; i <= 4; i++) do_push(0, 32'(i));
        check("t2_push_ready0", push_ready[0], 1'b0);
        check("t2_any_full", any_full, 1'b1);
        do_push(0, 32'h5);
        req_ready[0] = 1'b1;
        repeat (4) cyc();
        check("t2_empty0", req_valid[0], 1'b0);
        req_ready = '0;
        cyc();

        // Acc 2 held at two entries while pushing and transferring together
        do_push(2, 32'hA0);
        do_push(2, 32'hA1);
        req_ready[2] = 1'b1;
        for (int i = 2; i < 12; i++) begin
            push      = 1'b1;
            push_acc  = 2'd2;
            push_data = 32'hA0 + 32'(i);
            cyc();
        end
        push = 1'b0;
        drain();

        // Interleaved pushes with random per-accumulator ready
        for (int i = 0; i < 30; i++) begin
            req_ready = 3'($urandom_range(0, 7));
            if (exp_q[i % 3].size() < D) begin
                push      = 1'b1;
                push_acc  = acc_idx_t'(i % 3);
                push_data = 32'h100 * 32'(i % 3) + 32'(i);
            end else begin
                push = 1'b0;
            end
            cyc();
        end
        push = 1'b0;
        drain();

        // Asynchronous reset with acc 1 holding three entries
        for (int i = 0; i < 3; i++) do_push(1, 32'hB0 + 32'(i));
        check("t5_pre_valid", req_valid[1], 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_valid", req_valid, '0);
        check("t5_async_empty", all_empty, 1'b1);
        @(posedge clk);
        #2 reset_n = 1'b1;
        req_ready = '1;
        cyc();
        check("t5_no_stale", req_valid, '0);
        repeat (2) cyc();
        req_ready = '0;

        // Long back-pressure: head data must hold until the grant
        do_push(0, 32'hDEAD_BEEF);
        do_push(0, 32'h1234_5678);
        repeat (50) cyc();
        check("t6_hold_data", req_data[0], 32'hDEAD_BEEF);
        drain();

        // Out-of-range index is ignored
        do_push(3, 32'hFFFF_FFFF);
        check("t7_ignored", all_empty, 1'b1);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
